// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths and read-mode type for the synchronous FIFO
package fifo_pkg;

    typedef enum logic {
        READ_STD  = 1'b0,
        READ_FWFT = 1'b1
    } read_mode_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic read_mode_e read_mode(input int fwft);
        return (fwft != 0) ? READ_FWFT : READ_STD;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register-array storage with one write port and an asynchronous read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BUFFER_DEPTH = 8,
    localparam int ADDR_W      = ptr_width(BUFFER_DEPTH) - 1
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

    // Store the accepted word; contents are never reset
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with fill level, thresholds, FWFT option and sticky error flags
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int BUFFER_DEPTH     = 8,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_LVL  = BUFFER_DEPTH - 1,
    parameter int ALMOST_EMPTY_LVL = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                we_i,
    input  logic [DATA_WIDTH-1:0]               din_i,
    output logic                                wrdy_o,
    input  logic                                re_i,
    output logic [DATA_WIDTH-1:0]               dout_o,
    output logic                                rrdy_o,
    output logic [ptr_width(BUFFER_DEPTH)-1:0]  level_o,
    output logic                                almost_full_o,
    output logic                                almost_empty_o,
    input  logic                                clr_err_i,
    output logic                                overflow_o,
    output logic                                underflow_o
);

    localparam int PTR_W = ptr_width(BUFFER_DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam read_mode_e MODE = read_mode(FWFT);
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(ALMOST_FULL_LVL);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(ALMOST_EMPTY_LVL);

    if (BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("BUFFER_DEPTH must be a power of two >= 2");
    end
    if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > BUFFER_DEPTH) begin : g_bad_af
        $error("ALMOST_FULL_LVL out of range 1..BUFFER_DEPTH");
    end
    if (ALMOST_EMPTY_LVL < 0 || ALMOST_EMPTY_LVL > BUFFER_DEPTH - 1) begin : g_bad_ae
        $error("ALMOST_EMPTY_LVL out of range 0..BUFFER_DEPTH-1");
    end

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic empty, full, wr_en, rd_en;

    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign wr_en = we_i & ~full;
    assign rd_en = re_i & ~empty;

    assign wrdy_o = ~full;
    assign rrdy_o = ~empty;
    assign level_o = wr_ptr - rd_ptr;
    assign almost_full_o = level_o >= AF_LVL;
    assign almost_empty_o = level_o <= AE_LVL;

    fifo_mem #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (wr_en),
        .waddr_i(wr_ptr[ADDR_W-1:0]),
        .wdata_i(din_i),
        .raddr_i(rd_ptr[ADDR_W-1:0]),
        .rdata_o(rd_data)
    );

    // Advance pointers on accepted operations; binary wrap is natural
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Sticky error flags; a new violation wins over a clear in the same cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= (we_i & full) | (overflow_o & ~clr_err_i);
            underflow_o <= (re_i & empty) | (underflow_o & ~clr_err_i);
        end
    end

    if (MODE == READ_FWFT) begin : g_fwft
        assign dout_o = rd_data;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        // Capture the head word when a read is accepted, hold otherwise
        always_ff @(posedge clk_i) begin
            if (rst_i) dout_q <= '0;
            else if (rd_en) dout_q <= rd_data;
        end
        assign dout_o = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed checks of standard and FWFT FIFO instances
module tb_sync_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic we0 = 0, re0 = 0, clr0 = 0;
    logic we1 = 0, re1 = 0, clr1 = 0;
    logic [7:0] din0 = 0, din1 = 0;
    logic wrdy0, rrdy0, af0, ae0, ovf0, udf0;
    logic wrdy1, rrdy1, af1, ae1, ovf1, udf1;
    logic [7:0] dout0, dout1;
    logic [2:0] lvl0, lvl1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .BUFFER_DEPTH(4), .FWFT(0), .ALMOST_FULL_LVL(3), .ALMOST_EMPTY_LVL(1)) u0 (
        .clk_i(clk), .rst_i(rst), .we_i(we0), .din_i(din0), .wrdy_o(wrdy0), .re_i(re0),
        .dout_o(dout0), .rrdy_o(rrdy0), .level_o(lvl0), .almost_full_o(af0), .almost_empty_o(ae0),
        .clr_err_i(clr0), .overflow_o(ovf0), .underflow_o(udf0)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(8), .BUFFER_DEPTH(4), .FWFT(1), .ALMOST_FULL_LVL(3), .ALMOST_EMPTY_LVL(1)) u1 (
        .clk_i(clk), .rst_i(rst), .we_i(we1), .din_i(din1), .wrdy_o(wrdy1), .re_i(re1),
        .dout_o(dout1), .rrdy_o(rrdy1), .level_o(lvl1), .almost_full_o(af1), .almost_empty_o(ae1),
        .clr_err_i(clr1), .overflow_o(ovf1), .underflow_o(udf1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 0;
        chk("rst_level", lvl0, 0);
        chk("rst_wrdy", wrdy0, 1);
        chk("rst_rrdy", rrdy0, 0);
        chk("rst_af", af0, 0);
        chk("rst_ae", ae0, 1);
        chk("rst_ovf", ovf0, 0);
        chk("rst_udf", udf0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_rrdy_fwft", rrdy1, 0);

        // fill with A1..A4
        for (int i = 0; i < 4; i++) begin
            we0 = 1;
            din0 = 8'hA1 + 8'(i);
            tick();
            chk("fill_level", lvl0, i + 1);
            chk("fill_ae", ae0, (i + 1) <= 1);
            chk("fill_af", af0, (i + 1) >= 3);
            chk("fill_wrdy", wrdy0, (i + 1) != 4);
            chk("fill_rrdy", rrdy0, 1);
        end

        // write while full
        din0 = 8'hFF;
        tick();
        we0 = 0;
        chk("ovf_level", lvl0, 4);
        chk("ovf_flag", ovf0, 1);
        chk("ovf_udf", udf0, 0);

        // drain
        for (int i = 0; i < 4; i++) begin
            re0 = 1;
            tick();
            chk("drain_dout", dout0, 8'hA1 + i);
            chk("drain_level", lvl0, 3 - i);
        end
        chk("drain_rrdy", rrdy0, 0);
        chk("drain_wrdy", wrdy0, 1);

        // read while empty
        tick();
        re0 = 0;
        chk("udf_flag", udf0, 1);
        chk("udf_level", lvl0, 0);
        chk("udf_dout_hold", dout0, 8'hA4);

        clr0 = 1;
        tick();
        clr0 = 0;
        chk("clr_ovf", ovf0, 0);
        chk("clr_udf", udf0, 0);

        // set beats clear
        clr0 = 1;
        re0 = 1;
        tick();
        clr0 = 0;
        re0 = 0;
        chk("set_beats_clr", udf0, 1);
        clr0 = 1;
        tick();
        clr0 = 0;
        chk("clr_again", udf0, 0);

        // level 2 then streaming
        we0 = 1;
        din0 = 8'h00;
        tick();
        din0 = 8'h01;
        tick();
        chk("stream_pre_level", lvl0, 2);
        re0 = 1;
        for (int j = 0; j < 10; j++) begin
            din0 = 8'(j + 2);
            tick();
            chk("stream_level", lvl0, 2);
            chk("stream_dout", dout0, j);
        end
        we0 = 0;
        for (int j = 10; j < 12; j++) begin
            tick();
            chk("stream_tail", dout0, j);
        end
        re0 = 0;
        chk("stream_empty", lvl0, 0);
        chk("stream_rrdy", rrdy0, 0);

        // FWFT instance
        we1 = 1;
        din1 = 8'h5A;
        tick();
        din1 = 8'h3C;
        chk("fwft_rrdy", rrdy1, 1);
        chk("fwft_dout", dout1, 8'h5A);
        tick();
        we1 = 0;
        chk("fwft_level2", lvl1, 2);
        chk("fwft_head_kept", dout1, 8'h5A);
        re1 = 1;
        tick();
        chk("fwft_next", dout1, 8'h3C);
        chk("fwft_rrdy_mid", rrdy1, 1);
        tick();
        re1 = 0;
        chk("fwft_pop_rrdy", rrdy1, 0);
        chk("fwft_pop_level", lvl1, 0);

        // mid-operation reset with an error flag set
        re0 = 1;
        tick();
        re0 = 0;
        we0 = 1;
        for (int i = 0; i < 3; i++) begin
            din0 = 8'h21 + 8'(i);
            tick();
        end
        we0 = 0;
        chk("pre_rst_level", lvl0, 3);
        chk("pre_rst_udf", udf0, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_level", lvl0, 0);
        chk("mid_rst_rrdy", rrdy0, 0);
        chk("mid_rst_wrdy", wrdy0, 1);
        chk("mid_rst_ae", ae0, 1);
        chk("mid_rst_af", af0, 0);
        chk("mid_rst_udf", udf0, 0);
        chk("mid_rst_ovf", ovf0, 0);
        chk("mid_rst_dout", dout0, 0);
        we0 = 1;
        din0 = 8'h11;
        tick();
        we0 = 0;
        re0 = 1;
        tick();
        re0 = 0;
        chk("post_rst_dout", dout0, 8'h11);
        chk("post_rst_level", lvl0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised circular-buffer FIFO for same-domain buffering between producer/consumer blocks.
- Generalises the dual-clock Ndeep FIFO with these additions:
  - exact fill level;
  - programmable almost-full/almost-empty thresholds;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - sticky overflow/underflow error flags.
- No CDC inside; pointers are plain binary.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- BUFFER_DEPTH, 8, number of words; power of two, >= 2.
- FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through.
- ALMOST_FULL_LVL, BUFFER_DEPTH-1, almost_full_o asserted when level >= this; range 1..BUFFER_DEPTH.
- ALMOST_EMPTY_LVL, 1, almost_empty_o asserted when level <= this; range 0..BUFFER_DEPTH-1.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  one clock; reset is synchronous and active-high.
- we_i  in  1  write request.
- din_i  in  DATA_WIDTH  write data.
- wrdy_o  out  1  not full; write accepted when we_i & wrdy_o.
- re_i  in  1  read request.
- dout_o  out  DATA_WIDTH  read data.
- rrdy_o  out  1  not empty; read accepted when re_i & rrdy_o.
- level_o  out  $clog2(BUFFER_DEPTH)+1  words stored, 0..BUFFER_DEPTH.
- almost_full_o  out  1  level_o >= ALMOST_FULL_LVL.
- almost_empty_o  out  1  level_o <= ALMOST_EMPTY_LVL.
- clr_err_i  in  1  clears sticky error flags.
- overflow_o  out  1  sticky: write attempted while full.
- underflow_o  out  1  sticky: read attempted while empty.

Behaviour:
- Pointers: wr_ptr and rd_ptr, each $clog2(BUFFER_DEPTH)+1 bits; the MSB is the wrap bit. Index = low bits.
- empty: pointers equal.
- full: MSBs differ and low bits equal.
- level_o = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- All status outputs are combinational from registered pointers and reflect the state after the last clock edge.
- Write: on we_i & ~full, store din_i at index and increment wr_ptr. Visible in level_o/rrdy_o the next cycle.
- Read, FWFT=0: on re_i & ~empty, dout_o is registered from the head word and valid the cycle after acceptance. dout_o holds its value otherwise.
- Read, FWFT=1: dout_o shows the head word combinationally whenever rrdy_o=1; re_i & rrdy_o pops it. dout_o is don't-care when empty.
- Simultaneous write at full with read: the write is rejected (gated by the pre-edge wrdy_o); only the read occurs.
- Simultaneous read at empty with write: the read is rejected; the write occurs.
- Otherwise simultaneous read+write: both occur, level unchanged.
- Wrap-around: pointers roll over naturally; no special casing.
- Error flags:
  - overflow_o sets on we_i & full.
  - underflow_o sets on re_i & empty.
  - Both cleared by clr_err_i.
  - Set beats clear in the same cycle.
  - Rejected operations never modify storage or pointers.
- Reset (rst_i=1 at an edge, including mid-operation):
  - pointers 0, level_o 0;
  - wrdy_o 1, rrdy_o 0;
  - almost_full_o 0, almost_empty_o 1;
  - overflow_o/underflow_o 0;
  - registered dout_o 0.
- Storage array is not reset; prior contents become unreachable.

Decomposition:
- Package fifo_pkg: function for the pointer width (clog2+1), and a typedef of the read-mode enum (STD, FWFT) mapped to the FWFT parameter.
- One sub-module fifo_mem: DATA_WIDTH x BUFFER_DEPTH register array with one write port and an asynchronous read port. The controller adds the output register for FWFT=0.
- Parameter legality checks (power-of-two depth, threshold ranges) are elaboration-time assertions in the top.

Test Plan:
- DEPTH=4, AF=3, AE=1, FWFT=0; write 0xA1..0xA4 on consecutive cycles -> level_o 1,2,3,4; almost_empty_o drops at level 2; almost_full_o rises at level 3; wrdy_o=0 at level 4.
- From full, we_i with 0xFF -> level stays 4, overflow_o=1 next cycle. Then read 4 words -> dout_o = A1,A2,A3,A4, each one cycle after its re_i; rrdy_o=0 after the last.
- Empty, re_i=1 -> underflow_o=1, level 0. Pulse clr_err_i -> both flags 0. clr_err_i together with re_i at empty -> underflow_o stays 1.
- Level 2, simultaneous we_i/re_i for 10 cycles with incrementing data 0x00.. -> level_o constant 2, pointers wrap at least twice, output sequence preserved with no loss or duplication.
- FWFT=1, empty, write 0x5A -> next cycle rrdy_o=1 and dout_o=0x5A without re_i. re_i pops -> rrdy_o=0 next cycle.
- Level 3, assert rst_i for one cycle -> next cycle level_o 0, rrdy_o 0, wrdy_o 1, almost_empty_o 1, error flags 0. Subsequent write 0x11 then read returns 0x11.
